// File: rtl/seg_wb_writer.sv
// seg_wb_writer
// Wishbone pipelined initiator that copies a 32-bit value onto an 8-digit
// segment display. It does this as eight single-beat writes, one per digit
// register, at BASE + 4*i. Digit i receives {27'h0, blank[i], value[4i+3:4i]}.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   start_i             request an update (sampled only while idle)
//   value_i, blank_i    value / per-digit blank flags, latched on start
//   busy_o              sequence in flight
//   done_o              one-cycle pulse when a sequence ends (ok or aborted)
//   err_o               sticky ack-timeout flag, cleared by the next start
//   wb_*                Wishbone pipelined initiator port (write only)
//
// Parameters:
//   BASE     byte address of digit 0
//   TIMEOUT  max cycles from request issue to ack; 0 disables the timeout
module seg_wb_writer #(
  parameter logic [31:0] BASE    = 32'h0,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] value_i,
  input  logic [7:0]  blank_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i
);

  // The counter only ever needs to hold 0 .. TIMEOUT-1; the abort fires on
  // the edge that would take it to TIMEOUT.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [31:0]   val_q, val_n;
  logic [7:0]    blank_q, blank_n;
  logic [TW-1:0] tcnt, tcnt_n;

  logic        busy_n, done_n, err_n, cyc_n, stb_n, we_n;
  logic [31:0] adr_n, dat_n;
  logic [3:0]  sel_n;

  logic accepted;
  logic beat_ack;

  function automatic logic [31:0] digit_addr(input logic [2:0] i);
    return BASE + {27'h0, i, 2'b00};
  endfunction

  function automatic logic [31:0] digit_data(input logic [31:0] v,
                                             input logic [7:0]  b,
                                             input logic [2:0]  i);
    return {27'h0, b[i], v[{i, 2'b00} +: 4]};
  endfunction

  // An ack only counts once the current request has left REQ: either in
  // WAIT, or on the very edge the slave takes the request (stall low).
  assign accepted = (state == REQ) && !wb_stall_i;
  assign beat_ack = wb_ack_i && (accepted || (state == WAIT));

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so nothing on the bus is combinational.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    val_n   = val_q;
    blank_n = blank_q;
    tcnt_n  = tcnt;
    busy_n  = busy_o;
    done_n  = 1'b0;
    err_n   = err_o;
    cyc_n   = wb_cyc_o;
    stb_n   = wb_stb_o;
    adr_n   = wb_adr_o;
    dat_n   = wb_dat_o;

    case (state)
      IDLE: begin
        if (start_i) begin
          val_n   = value_i;
          blank_n = blank_i;
          idx_n   = 3'd0;
          err_n   = 1'b0;
          tcnt_n  = '0;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          adr_n   = digit_addr(3'd0);
          dat_n   = digit_data(value_i, blank_i, 3'd0);
          busy_n  = 1'b1;
          state_n = REQ;
        end
      end

      REQ, WAIT: begin
        if (beat_ack) begin
          tcnt_n = '0;
          if (idx != 3'd7) begin
            idx_n   = idx + 3'd1;
            stb_n   = 1'b1;
            adr_n   = digit_addr(idx + 3'd1);
            dat_n   = digit_data(val_q, blank_q, idx + 3'd1);
            state_n = REQ;
          end else begin
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else if (TIMEOUT_EN && (tcnt == TLAST)) begin
          // Slave never answered: abandon the remaining digits.
          tcnt_n  = '0;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          busy_n  = 1'b0;
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (accepted) begin
            stb_n   = 1'b0;
            state_n = WAIT;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    we_n  = stb_n;
    sel_n = {4{stb_n}};
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      idx      <= 3'd0;
      val_q    <= 32'h0;
      blank_q  <= 8'h0;
      tcnt     <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
      wb_sel_o <= 4'h0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      val_q    <= val_n;
      blank_q  <= blank_n;
      tcnt     <= tcnt_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
      err_o    <= err_n;
      wb_cyc_o <= cyc_n;
      wb_stb_o <= stb_n;
      wb_we_o  <= we_n;
      wb_adr_o <= adr_n;
      wb_dat_o <= dat_n;
      wb_sel_o <= sel_n;
    end
  end

endmodule

// File: tb/tb_seg_wb_writer.sv
// tb_seg_wb_writer
// Bench for seg_wb_writer. A behavioural Wishbone slave with configurable
// stall length, ack delay and a "never ack this beat" option records every
// acknowledged write. The expected writes are derived from value/blank with
// plain arithmetic. The expected cyc duration is 8 * (stall + 1 + ack delay).
module tb_seg_wb_writer;

  localparam logic [31:0] BASE_TB = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = 32'h0;
  logic [7:0]  blank = 8'h0;
  logic        stall = 1'b0;
  logic        ack = 1'b0;
  logic        busy, done, err, cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;

  seg_wb_writer #(.BASE(BASE_TB), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .value_i(value), .blank_i(blank),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
    .wb_dat_o(dat), .wb_sel_o(sel), .wb_stall_i(stall), .wb_ack_i(ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // slave configuration
  int stallCfg = 0;
  int ackDly = 1;
  int noAckBeat = 99;
  bit idleAck = 1'b0;
  bit stallAck = 1'b0;

  // slave state and observations
  int stallLeft = 0;
  int ackIn = 0;
  int beatIdx = 0;
  bit inBeat = 1'b0;
  bit ackArmed = 1'b0;
  logic [63:0] pend;
  logic [31:0] holdAdr, holdDat;
  logic [63:0] wlog[$];
  int unstableCnt = 0;
  int badCtl = 0;
  int cycCount = 0;
  int doneCount = 0;
  int acceptCnt = 0;

  function automatic logic [63:0] expWrite(logic [31:0] v, logic [7:0] b, int i);
    logic [31:0] a;
    logic [31:0] d;
    a = BASE_TB + 32'(4 * i);
    d = {27'h0, b[i], 4'((v >> (4 * i)) & 32'hF)};
    return {a, d};
  endfunction

  // Slave and monitor: decides stall/ack for the next rising edge.
  always @(negedge clk) begin
    if (cyc) cycCount++;
    if (done) doneCount++;
    if (stb && (!cyc || !we || sel != 4'hF)) badCtl++;
    if (!stb && (we || sel != 4'h0)) badCtl++;
    stall = 1'b0;
    ack = 1'b0;
    if (rst || !cyc) begin
      inBeat = 1'b0;
      ackArmed = 1'b0;
      ackIn = 0;
      beatIdx = 0;
      if (!rst && idleAck) ack = 1'b1;
    end else begin
      if (ackArmed) begin
        if (ackIn > 0) ackIn--;
        if (ackIn == 0) begin
          ack = 1'b1;
          ackArmed = 1'b0;
          wlog.push_back(pend);
        end
      end
      if (stb) begin
        if (!inBeat) begin
          inBeat = 1'b1;
          stallLeft = stallCfg;
          holdAdr = adr;
          holdDat = dat;
        end else if (adr !== holdAdr || dat !== holdDat) begin
          unstableCnt++;
        end
        if (stallLeft > 0) begin
          stall = 1'b1;
          stallLeft--;
          if (stallAck) ack = 1'b1;
        end else begin
          inBeat = 1'b0;
          acceptCnt++;
          pend = {adr, dat};
          if (beatIdx != noAckBeat) begin
            if (ackDly == 0) begin
              ack = 1'b1;
              wlog.push_back(pend);
            end else begin
              ackArmed = 1'b1;
              ackIn = ackDly;
            end
          end
          beatIdx++;
        end
      end
    end
  end

  task automatic pulseStart(input logic [31:0] v, input logic [7:0] b);
    @(negedge clk);
    value = v;
    blank = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value = $urandom;
    blank = 8'($urandom);
  endtask

  task automatic waitDone(input int d0, input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      #1;
      if (doneCount > d0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cyc, stb, we, sel} !== 7'h0) begin
      errors++;
      $display("[TB] FAIL reset_ctl: got %b expected 0", {cyc, stb, we, sel});
    end
    checks++;
    if ({adr, dat} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_adr_dat: got %h expected 0", {adr, dat});
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_status: got %b expected 000", {busy, done, err});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_ack;
    int d0;
    d0 = doneCount;
    idleAck = 1'b1;
    repeat (5) @(negedge clk);
    idleAck = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({cyc, busy, doneCount - d0} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL idle_ack: got cyc=%b busy=%b dones=%0d expected 0", cyc, busy, doneCount - d0);
    end
  endtask

  task automatic test_nominal;
    int base, c0, d0;
    bit ok;
    logic [31:0] v;
    v = 32'h89ABCDEF;
    stallCfg = 0; ackDly = 1;
    base = wlog.size(); c0 = cycCount; d0 = doneCount;
    pulseStart(v, 8'h00);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nominal_busy: got %b expected 1", busy);
    end
    waitDone(d0, 200, ok);
    checks++;
    if (!ok || wlog.size() != base + 8) begin
      errors++;
      $display("[TB] FAIL nominal_count: got done=%b writes=%0d expected 8", ok, wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wlog[base + i] !== expWrite(v, 8'h00, i)) begin
          errors++;
          $display("[TB] FAIL nominal_write%0d: got %h expected %h", i, wlog[base + i], expWrite(v, 8'h00, i));
        end
      end
    end
    checks++;
    if (cycCount - c0 != 16) begin
      errors++;
      $display("[TB] FAIL nominal_cyc_len: got %0d expected 16", cycCount - c0);
    end
    checks++;
    if (doneCount - d0 != 1 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nominal_end: got dones=%0d err=%b busy=%b expected 1 0 0", doneCount - d0, err, busy);
    end
  endtask

  task automatic test_stall_late_ack;
    int base, c0, d0, a0, u0, b0;
    bit ok;
    logic [31:0] v;
    logic [7:0] b;
    v = $urandom; b = 8'($urandom);
    stallCfg = 3; ackDly = 2; stallAck = 1'b1;
    base = wlog.size(); c0 = cycCount; d0 = doneCount;
    a0 = acceptCnt; u0 = unstableCnt; b0 = badCtl;
    pulseStart(v, b);
    waitDone(d0, 400, ok);
    stallAck = 1'b0;
    checks++;
    if (!ok || wlog.size() != base + 8) begin
      errors++;
      $display("[TB] FAIL stall_count: got done=%b writes=%0d expected 8", ok, wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wlog[base + i] !== expWrite(v, b, i)) begin
          errors++;
          $display("[TB] FAIL stall_write%0d: got %h expected %h", i, wlog[base + i], expWrite(v, b, i));
        end
      end
    end
    checks++;
    if (cycCount - c0 != 8 * (3 + 1 + 2)) begin
      errors++;
      $display("[TB] FAIL stall_cyc_len: got %0d expected %0d", cycCount - c0, 8 * 6);
    end
    checks++;
    if (acceptCnt - a0 != 8 || unstableCnt != u0 || badCtl != b0) begin
      errors++;
      $display("[TB] FAIL stall_bus: got accepts=%0d unstable=%0d badctl=%0d expected 8 0 0",
               acceptCnt - a0, unstableCnt - u0, badCtl - b0);
    end
  endtask

  task automatic test_same_edge_blank;
    int base, c0, d0;
    bit ok;
    stallCfg = 0; ackDly = 0;
    base = wlog.size(); c0 = cycCount; d0 = doneCount;
    pulseStart(32'h12345678, 8'h81);
    waitDone(d0, 200, ok);
    checks++;
    if (!ok || wlog.size() != base + 8) begin
      errors++;
      $display("[TB] FAIL same_edge_count: got done=%b writes=%0d expected 8", ok, wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wlog[base + i] !== expWrite(32'h12345678, 8'h81, i)) begin
          errors++;
          $display("[TB] FAIL same_edge_write%0d: got %h expected %h", i, wlog[base + i],
                   expWrite(32'h12345678, 8'h81, i));
        end
      end
      checks++;
      if (wlog[base][31:0] !== 32'h18 || wlog[base + 7][31:0] !== 32'h11) begin
        errors++;
        $display("[TB] FAIL same_edge_blank: got %h/%h expected 18/11", wlog[base][31:0], wlog[base + 7][31:0]);
      end
    end
    checks++;
    if (cycCount - c0 != 8 || doneCount - d0 != 1) begin
      errors++;
      $display("[TB] FAIL same_edge_len: got cyc=%0d dones=%0d expected 8 1", cycCount - c0, doneCount - d0);
    end
  endtask

  task automatic test_timeout;
    int base, c0, d0;
    bit ok;
    logic [31:0] v;
    v = $urandom;
    stallCfg = 0; ackDly = 1; noAckBeat = 3;
    base = wlog.size(); c0 = cycCount; d0 = doneCount;
    pulseStart(v, 8'h0F);
    waitDone(d0, 200, ok);
    noAckBeat = 99;
    checks++;
    if (!ok || wlog.size() != base + 3) begin
      errors++;
      $display("[TB] FAIL timeout_count: got done=%b writes=%0d expected 3", ok, wlog.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wlog[base + i] !== expWrite(v, 8'h0F, i)) begin
          errors++;
          $display("[TB] FAIL timeout_write%0d: got %h expected %h", i, wlog[base + i], expWrite(v, 8'h0F, i));
        end
      end
    end
    checks++;
    if (cycCount - c0 != 6 + 16) begin
      errors++;
      $display("[TB] FAIL timeout_cyc_len: got %0d expected 22", cycCount - c0);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || doneCount - d0 != 1) begin
      errors++;
      $display("[TB] FAIL timeout_status: got err=%b busy=%b dones=%0d expected 1 0 1", err, busy, doneCount - d0);
    end
    d0 = doneCount;
    pulseStart($urandom, 8'h00);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_err_clear: got %b expected 0", err);
    end
    waitDone(d0, 200, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_recover: got done=%b err=%b expected 1 0", ok, err);
    end
  endtask

  task automatic test_start_while_busy;
    int base, d0, c1;
    bit ok, hit;
    logic [31:0] v;
    logic [7:0] b;
    v = $urandom; b = 8'($urandom);
    stallCfg = 0; ackDly = 1;
    base = wlog.size(); d0 = doneCount;
    pulseStart(v, b);
    repeat (4) @(negedge clk);
    pulseStart(32'hFFFFFFFF, 8'hFF);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (beatIdx == 8 && ack) begin
        hit = 1'b1;
        break;
      end
    end
    value = 32'hFFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(d0, 50, ok);
    c1 = cycCount;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (!hit || !ok || wlog.size() != base + 8) begin
      errors++;
      $display("[TB] FAIL busy_start_count: got hit=%b done=%b writes=%0d expected 8", hit, ok, wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wlog[base + i] !== expWrite(v, b, i)) begin
          errors++;
          $display("[TB] FAIL busy_start_write%0d: got %h expected %h", i, wlog[base + i], expWrite(v, b, i));
        end
      end
    end
    checks++;
    if (cycCount != c1 || doneCount - d0 != 1) begin
      errors++;
      $display("[TB] FAIL busy_start_no_second: got cyc=%0d dones=%0d expected 0 1", cycCount - c1, doneCount - d0);
    end
  endtask

  task automatic test_reset_mid_burst;
    int base, c0, d0;
    bit ok, hit;
    logic [31:0] v;
    logic [7:0] b;
    stallCfg = 0; ackDly = 1;
    d0 = doneCount;
    pulseStart($urandom, 8'($urandom));
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (beatIdx == 5 && cyc && !stb) begin
        hit = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (!hit || {cyc, stb, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_mid_drop: got hit=%b cyc/stb/busy=%b expected 000", hit, {cyc, stb, busy});
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (doneCount != d0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_done: got %0d expected 0", doneCount - d0);
    end
    rst = 1'b0;
    v = $urandom; b = 8'($urandom);
    base = wlog.size(); c0 = cycCount; d0 = doneCount;
    pulseStart(v, b);
    waitDone(d0, 200, ok);
    checks++;
    if (!ok || wlog.size() != base + 8) begin
      errors++;
      $display("[TB] FAIL reset_mid_restart: got done=%b writes=%0d expected 8", ok, wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wlog[base + i] !== expWrite(v, b, i)) begin
          errors++;
          $display("[TB] FAIL reset_mid_write%0d: got %h expected %h", i, wlog[base + i], expWrite(v, b, i));
        end
      end
    end
    checks++;
    if (cycCount - c0 != 16) begin
      errors++;
      $display("[TB] FAIL reset_mid_cyc_len: got %0d expected 16", cycCount - c0);
    end
  endtask

  task automatic test_random;
    int base, c0, d0, b0, u0;
    bit ok;
    logic [31:0] v;
    logic [7:0] b;
    for (int n = 0; n < 6; n++) begin
      v = $urandom; b = 8'($urandom);
      stallCfg = $urandom_range(0, 3);
      ackDly = $urandom_range(0, 3);
      stallAck = 1'($urandom_range(0, 1));
      base = wlog.size(); c0 = cycCount; d0 = doneCount; b0 = badCtl; u0 = unstableCnt;
      pulseStart(v, b);
      waitDone(d0, 400, ok);
      checks++;
      if (!ok || wlog.size() != base + 8) begin
        errors++;
        $display("[TB] FAIL random%0d_count: got done=%b writes=%0d expected 8", n, ok, wlog.size() - base);
      end else begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (wlog[base + i] !== expWrite(v, b, i)) begin
            errors++;
            $display("[TB] FAIL random%0d_write%0d: got %h expected %h", n, i, wlog[base + i], expWrite(v, b, i));
          end
        end
      end
      checks++;
      if (cycCount - c0 != 8 * (stallCfg + 1 + ackDly) || badCtl != b0 || unstableCnt != u0 || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random%0d_timing: got cyc=%0d bad=%0d unstable=%0d err=%b expected %0d 0 0 0", n,
                 cycCount - c0, badCtl - b0, unstableCnt - u0, err, 8 * (stallCfg + 1 + ackDly));
      end
    end
    stallAck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_ack();
    test_nominal();
    test_stall_late_ack();
    test_same_edge_blank();
    test_timeout();
    test_start_while_busy();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_wb_writer.md
Name: seg_wb_writer

Overview:
- Wishbone pipelined initiator that pushes a 32-bit value to an 8-digit segment display controller.
- Performs eight single-beat writes, one nibble per digit register, at BASE + 4*i.
- Sits between a CPU-less status source (debug counter, POST code) and the display slave on the shared bus.
- Handles stall, ack and ack timeout.

Parameters:
- BASE, 32'h0, byte address of digit 0; digit i written at BASE + 4*i.
- TIMEOUT, 16, max cycles from request issue to ack; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request a display update; sampled only in IDLE
- value_i  in  32  value to display; nibble i goes to digit i
- blank_i  in  8  per-digit blank flag, written as data bit 4
- busy_o  out  1  high from the cycle after start is accepted until done
- done_o  out  1  one-cycle pulse at end of a sequence (success or abort)
- err_o  out  1  sticky timeout flag; cleared on the next accepted start
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable, always 1 while stb is high
- wb_adr_o  out  32  address
- wb_dat_o  out  32  write data, {27'h0, blank[i], value[4i+3:4i]}
- wb_sel_o  out  4  4'hF while stb is high, else 0
- wb_stall_i  in  1  slave stall
- wb_ack_i  in  1  slave ack

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, digit index 0, timeout counter 0, err_o 0.
- All outputs are registered.
- Reset asserted mid-sequence drops cyc/stb immediately (async); no done pulse is produced.

States:
- IDLE:
  - start_i=1 at a clock edge → latch value_i and blank_i, index=0, clear err_o.
  - Same edge: assert cyc=stb=we=1, drive adr=BASE and data for digit 0, set busy=1, go to REQ.
- REQ:
  - stb held with adr/dat stable.
  - At an edge with wb_stall_i=0, the request is accepted: drop stb, go to WAIT.
  - If wb_ack_i=1 at that same edge, treat it as the ack for this beat and go directly to the advance step.
- WAIT:
  - cyc held, stb=0.
  - At an edge with wb_ack_i=1, advance:
    - index<7: index+1, assert stb with next adr/dat, go to REQ.
    - index==7: drop cyc, busy=0, done=1 for one cycle, go to IDLE.
- Timing: with stall=0 and ack one cycle after acceptance, each digit takes 2 cycles.
  - cyc is high for exactly 16 cycles.
  - done is asserted the cycle after cyc falls... precisely: at the edge that samples the final ack, cyc falls and done rises.
- cyc stays high continuously across all eight beats. At most one request is outstanding.

Timeout:
- Counter clears on each request issue and increments every cycle in REQ or WAIT.
- On reaching TIMEOUT with no ack: drop cyc/stb, set err_o=1, pulse done, busy=0, go to IDLE. Remaining digits are not written.

Other boundary conditions:
- wb_ack_i in IDLE, or in REQ before acceptance (stall=1 that edge), is ignored.
- start_i while busy is ignored and not queued.
- start_i in the same cycle as done is also ignored, because the FSM is not yet in IDLE.
- value_i/blank_i changes after acceptance have no effect on the sequence in flight.
- Address arithmetic is 32-bit modular: BASE + 4*i wraps with no error.

Test Plan:
- Nominal: BASE=0x100, value=0x89ABCDEF, blank=0, responder stall=0 with ack 1 cycle after acceptance → writes 0x100:0xF, 0x104:0xE, …, 0x11C:0x8; cyc high 16 cycles; single done pulse; err_o=0.
- Stall and late ack: responder stalls 3 cycles on each beat and acks 2 cycles after acceptance → same 8 writes in order; adr/dat stable throughout stall; exactly one stb acceptance per beat.
- Same-edge ack and blank: ack in the acceptance cycle, blank=8'h81, value=0x12345678 → digit0 data 0x18, digit7 data 0x11, others nibble only; 8 cycles total with cyc high.
- Timeout: TIMEOUT=16, responder never acks digit 3 → digits 0–2 written; cyc drops 16 cycles after digit 3 issue; err_o=1 and done pulse; next start clears err_o.
- Start while busy: second start with value=0xFFFFFFFF mid-sequence → ignored; the latched value completes; no second sequence.
- Reset mid-burst: assert rst_i during digit 4 WAIT → cyc/stb/busy go 0 immediately; no done pulse; a subsequent start restarts at digit 0.
